// File: rtl/prover_compute_v_sr_ctrl.sv
// prover_compute_v_sr_ctrl
// Round sequencer for the prover V-shift-register datapath. One `start` runs
// a full sumcheck trip of nRounds rounds. Each round:
//   1. accept a challenge tau over a valid/ready handshake;
//   2. register tau and (1 - tau) mod F_Q;
//   3. pulse vsr_en for one cycle (with vsr_restart on the first round only);
//   4. wait for vsr_ready_pulse from the datapath.
//
// Ports:
//   clk, rstb        clock, synchronous active-high reset
//   start            begin a trip (IDLE only)
//   tau_in/valid     challenge input; tau_ready is the handshake reply
//   vsr_en           one-cycle launch strobe
//   vsr_restart      restart flag for the datapath
//   tau, m_tau_p1    held challenge and (1 - tau) mod F_Q
//   vsr_ready_pulse  round-complete pulse from the datapath
//   vsr_gates_en     per-gate strobe from the datapath
//   round            current 0-based round index
//   busy, done       trip status
//   err              sticky gate-count error
//
// Build option: define PROVER_VSR_CTRL_GATECHK_EN to build the per-round
// gate counter and its checker. Without it, err is tied to 0.
module prover_compute_v_sr_ctrl #(
  parameter int nCopyBits   = 4,
  parameter int totParallel = 4,
  parameter int nRounds     = nCopyBits + $clog2(totParallel) + 2,
  parameter int F_NBITS     = 61,
  parameter logic [F_NBITS-1:0] F_Q = {F_NBITS{1'b1}}
) (
  input  logic                             clk,
  input  logic                             rstb,
  input  logic                             start,
  input  logic [F_NBITS-1:0]               tau_in,
  input  logic                             tau_valid,
  output logic                             tau_ready,
  output logic                             vsr_en,
  output logic                             vsr_restart,
  output logic [F_NBITS-1:0]               tau,
  output logic [F_NBITS-1:0]               m_tau_p1,
  input  logic                             vsr_ready_pulse,
  input  logic                             vsr_gates_en,
  output logic [$clog2(nRounds+1)-1:0]     round,
  output logic                             busy,
  output logic                             done,
  output logic                             err
);
  localparam int RW = $clog2(nRounds + 1);
  localparam int CW = nCopyBits + 1;
  localparam logic [F_NBITS:0] Q_EXT    = {1'b0, F_Q};
  localparam logic [F_NBITS:0] Q_PLUS_1 = Q_EXT + {{F_NBITS{1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, WAIT_TAU, LAUNCH, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [RW-1:0]        round_q, round_d;
  logic                 restart_pending_q, restart_pending_d;
  logic [F_NBITS-1:0]   tau_q, tau_d;
  logic [F_NBITS-1:0]   m_tau_p1_q, m_tau_p1_d;
  logic                 tau_ready_q, tau_ready_d;
  logic                 vsr_en_q, vsr_en_d;
  logic                 vsr_restart_q, vsr_restart_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [F_NBITS:0]     m_sum;
  logic [F_NBITS:0]     m_red;

  // (1 - tau) mod F_Q computed as (F_Q + 1 - tau) with one conditional
  // subtraction; tau < F_Q keeps the sum within [2, F_Q + 1].
  always_comb begin
    m_sum = Q_PLUS_1 - {1'b0, tau_in};
    m_red = (m_sum >= Q_EXT) ? (m_sum - Q_EXT) : m_sum;
  end

  always_comb begin
    state_d           = state_q;
    round_d           = round_q;
    restart_pending_d = restart_pending_q;
    tau_d             = tau_q;
    m_tau_p1_d        = m_tau_p1_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d           = WAIT_TAU;
          round_d           = '0;
          restart_pending_d = 1'b1;
        end
      end
      WAIT_TAU: begin
        if (tau_ready_q && tau_valid) begin
          tau_d      = tau_in;
          m_tau_p1_d = m_red[F_NBITS-1:0];
          state_d    = LAUNCH;
        end
      end
      LAUNCH: begin
        restart_pending_d = 1'b0;
        state_d           = RUN;
      end
      RUN: begin
        if (vsr_ready_pulse) begin
          if (round_q == RW'(nRounds - 1)) begin
            state_d = DONE;
          end else begin
            round_d = round_q + 1'b1;
            state_d = WAIT_TAU;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next state so they line up with it.
    tau_ready_d   = (state_d == WAIT_TAU);
    vsr_en_d      = (state_d == LAUNCH);
    vsr_restart_d = (state_d == LAUNCH) && restart_pending_q;
    busy_d        = (state_d != IDLE);
    done_d        = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      state_q           <= IDLE;
      round_q           <= '0;
      restart_pending_q <= 1'b0;
      tau_q             <= '0;
      m_tau_p1_q        <= '0;
      tau_ready_q       <= 1'b0;
      vsr_en_q          <= 1'b0;
      vsr_restart_q     <= 1'b0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
    end else begin
      state_q           <= state_d;
      round_q           <= round_d;
      restart_pending_q <= restart_pending_d;
      tau_q             <= tau_d;
      m_tau_p1_q        <= m_tau_p1_d;
      tau_ready_q       <= tau_ready_d;
      vsr_en_q          <= vsr_en_d;
      vsr_restart_q     <= vsr_restart_d;
      busy_q            <= busy_d;
      done_q            <= done_d;
    end
  end

`ifdef PROVER_VSR_CTRL_GATECHK_EN
  logic [CW-1:0] gate_cnt_q, gate_cnt_d;
  logic [CW-1:0] cnt_final;
  logic [CW-1:0] exp_cnt;
  logic [RW-1:0] shamt;
  logic          err_q, err_d;

  always_comb begin
    // Count including a strobe that lands in the same cycle; saturate at max.
    cnt_final = gate_cnt_q;
    if (vsr_gates_en && (gate_cnt_q != {CW{1'b1}})) begin
      cnt_final = gate_cnt_q + 1'b1;
    end
    // Halving schedule: 2^(nCopyBits-1-r) for early rounds, then 1.
    shamt   = RW'(nCopyBits - 1) - round_q;
    exp_cnt = {{(CW-1){1'b0}}, 1'b1};
    if (round_q < RW'(nCopyBits)) begin
      exp_cnt = {{(CW-1){1'b0}}, 1'b1} << shamt;
    end

    gate_cnt_d = gate_cnt_q;
    err_d      = err_q;
    if ((state_q == IDLE) && start) begin
      err_d = 1'b0;
    end
    if (state_q == LAUNCH) begin
      gate_cnt_d = '0;
    end
    if (state_q == RUN) begin
      gate_cnt_d = cnt_final;
      if (vsr_ready_pulse && (cnt_final != exp_cnt)) begin
        err_d = 1'b1;
      end
    end else if (vsr_gates_en) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      gate_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      gate_cnt_q <= gate_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err = err_q;
`else
  logic gates_unused;
  assign gates_unused = vsr_gates_en;
  assign err          = 1'b0;
`endif

  assign tau_ready   = tau_ready_q;
  assign vsr_en      = vsr_en_q;
  assign vsr_restart = vsr_restart_q;
  assign tau         = tau_q;
  assign m_tau_p1    = m_tau_p1_q;
  assign round       = round_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
